dmem_arbiter: RTL and testbench

Two-port arbiter sharing the single-cycle core's data memory between the core load/store path (port 0) and a debug/DMA master (port 1). One transaction is issued per cycle, with round-robin fairness and a bounded lock for port-1 bursts. Read data is routed back through a tag pipeline that matches the memory's fixed read latency. The block sits between the core's ALU-address/store-data path and the `Memory` instance, and supplies the core's stall signal.

---
 rtl/dmem_arb_pkg.sv | 22 ++
 rtl/dmem_rsp_pipe.sv | 42 ++++
 rtl/dmem_arbiter.sv | 150 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM states, response tags
// and the port index constants used to label requesters.
package dmem_arb_pkg;

  typedef enum logic {ARB = 1'b0, LOCK = 1'b1} arb_state_t;

  typedef struct packed {
    logic valid;
    logic id;
  } rsp_tag_t;

  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_DBG  = 1'b1;

  function automatic rsp_tag_t make_tag(input logic valid, input logic id);
    rsp_tag_t t;
    t.valid = valid;
    t.id    = id;
    return t;
  endfunction

endpackage

// File: rtl/dmem_rsp_pipe.sv
// Fixed-depth shift register of response tags; the tail entry lines up with
// the memory's read data, and the whole pipe clears on reset.
module dmem_rsp_pipe
  import dmem_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 1
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  rsp_tag_t push_tag,
  output rsp_tag_t pop_tag
);

  rsp_tag_t [DEPTH-1:0] pipe_q;
  rsp_tag_t [DEPTH-1:0] pipe_d;
  rsp_tag_t             head_s;

  assign head_s = push ? push_tag : make_tag(1'b0, 1'b0);

  generate
    if (DEPTH == 1) begin : g_one
      // single stage: the pushed tag is the tail on the next cycle
      always_comb pipe_d = head_s;
    end else begin : g_many
      // shift toward the tail, new tag enters at stage 0
      always_comb pipe_d = {pipe_q[DEPTH-2:0], head_s};
    end
  endgenerate

  // tag storage, dropped entirely on reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign pop_tag = pipe_q[DEPTH-1];

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of the data memory, with a bounded
// burst lock for the debug/DMA port and tagged read-data return.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned AW       = 32,
  parameter int unsigned DW       = 32,
  parameter int unsigned MEM_LAT  = 1,
  parameter int unsigned MAX_LOCK = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  input  logic          lock1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          core_stall,
  output logic          mem_read_en,
  output logic          mem_write_en,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int unsigned    CW         = $clog2(MAX_LOCK + 1);
  localparam logic [CW-1:0]  LOCK_LIMIT = CW'(MAX_LOCK);

  arb_state_t    state_q, state_d;
  logic          prio_q, prio_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          arb_gnt0_s, arb_gnt1_s;
  logic          win_we_s;
  rsp_tag_t      tail_s;

  // grant selection and next-state for the round-robin / lock FSM
  always_comb begin
    state_d    = state_q;
    prio_d     = prio_q;
    cnt_d      = cnt_q;
    arb_gnt0_s = 1'b0;
    arb_gnt1_s = 1'b0;
    case (state_q)
      ARB: begin
        if (req0 && req1) begin
          arb_gnt0_s = (prio_q == PORT_CORE);
          arb_gnt1_s = (prio_q == PORT_DBG);
        end else begin
          arb_gnt0_s = req0;
          arb_gnt1_s = req1;
        end
        if (arb_gnt0_s) begin
          prio_d = PORT_DBG;
        end else if (arb_gnt1_s) begin
          prio_d = PORT_CORE;
          // a limit of one means the entering grant already used the burst
          if (lock1 && (LOCK_LIMIT > CW'(1))) begin
            state_d = LOCK;
            cnt_d   = CW'(1);
          end else begin
            state_d = ARB;
            cnt_d   = '0;
          end
        end else begin
          prio_d = prio_q;
        end
      end
      LOCK: begin
        arb_gnt1_s = req1;
        if (req1 && lock1 && ((cnt_q + CW'(1)) < LOCK_LIMIT)) begin
          cnt_d = cnt_q + CW'(1);
        end else begin
          // prio back to the core so a forced release lets port 0 in next
          state_d = ARB;
          prio_d  = PORT_CORE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ARB;
        prio_d  = PORT_CORE;
        cnt_d   = '0;
      end
    endcase
  end

  // arbitration state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ARB;
      prio_q  <= PORT_CORE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      cnt_q   <= cnt_d;
    end
  end

  assign gnt0       = rst & arb_gnt0_s;
  assign gnt1       = rst & arb_gnt1_s;
  assign core_stall = rst & req0 & ~gnt0;

  // route the winning request to memory, idle bus when nobody wins
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    win_we_s  = 1'b0;
    if (gnt0) begin
      mem_addr  = addr0;
      mem_wdata = wdata0;
      win_we_s  = we0;
    end else if (gnt1) begin
      mem_addr  = addr1;
      mem_wdata = wdata1;
      win_we_s  = we1;
    end else begin
      mem_addr  = '0;
      mem_wdata = '0;
      win_we_s  = 1'b0;
    end
  end

  assign mem_read_en  = (gnt0 | gnt1) & ~win_we_s;
  assign mem_write_en = (gnt0 | gnt1) & win_we_s;

  dmem_rsp_pipe #(.DEPTH(MEM_LAT)) u_rsp_pipe (
    .clk      (clk),
    .rst      (rst),
    .push     (mem_read_en),
    .push_tag (make_tag(1'b1, gnt1)),
    .pop_tag  (tail_s)
  );

  assign rvalid0 = tail_s.valid & (tail_s.id == PORT_CORE);
  assign rvalid1 = tail_s.valid & (tail_s.id == PORT_DBG);
  assign rdata0  = rvalid0 ? mem_rdata : '0;
  assign rdata1  = rvalid1 ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: three instances (read latency 1, 2, 3) share one
// stimulus stream and are checked every cycle against a request-level model.
module tb_dmem_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int NI   = 3;
  localparam int MAXL = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0, req1, we0, we1, lock1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;

  logic          gnt0_w[NI], gnt1_w[NI], rvalid0_w[NI], rvalid1_w[NI];
  logic          stall_w[NI], mre_w[NI], mwe_w[NI];
  logic [AW-1:0] maddr_w[NI];
  logic [DW-1:0] mwdata_w[NI], rdata0_w[NI], rdata1_w[NI], mrdata_w[NI];

  always #5 clk = ~clk;

  // memory model: read data appears exactly LAT cycles after a read issue
  logic          mp_v[NI][4];
  logic [DW-1:0] mp_dat[NI][4];
  logic          rd_now[NI];
  logic [DW-1:0] rd_val[NI];
  int            cyc = 0;

  function automatic logic [DW-1:0] mem_f(input logic [AW-1:0] a);
    return a ^ 32'h1234_5678;
  endfunction

  generate
    for (genvar k = 0; k < NI; k++) begin : g_dut
      assign mrdata_w[k] = mp_v[k][k] ? mp_dat[k][k] : (32'hBAD0_0000 | 32'(cyc));
      dmem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(k + 1), .MAX_LOCK(MAXL)) u_dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .lock1(lock1),
        .gnt0(gnt0_w[k]), .gnt1(gnt1_w[k]),
        .rvalid0(rvalid0_w[k]), .rvalid1(rvalid1_w[k]),
        .rdata0(rdata0_w[k]), .rdata1(rdata1_w[k]),
        .core_stall(stall_w[k]),
        .mem_read_en(mre_w[k]), .mem_write_en(mwe_w[k]),
        .mem_addr(maddr_w[k]), .mem_wdata(mwdata_w[k]),
        .mem_rdata(mrdata_w[k])
      );
    end
  endgenerate

  initial begin
    for (int k = 0; k < NI; k++) begin
      rd_now[k] = 1'b0;
      rd_val[k] = '0;
      for (int s = 0; s < 4; s++) begin
        mp_v[k][s]   = 1'b0;
        mp_dat[k][s] = '0;
      end
    end
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      for (int k = 0; k < NI; k++) begin
        for (int s = 3; s > 0; s--) begin
          mp_v[k][s]   = mp_v[k][s-1];
          mp_dat[k][s] = mp_dat[k][s-1];
        end
        mp_v[k][0]   = rd_now[k];
        mp_dat[k][0] = rd_val[k];
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < NI; k++) begin
        rd_now[k] = mre_w[k];
        rd_val[k] = mem_f(maddr_w[k]);
      end
    end
  end

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s lat%0d cyc %0d: got %0h expected %0h", nm, k + 1, cyc, act, exp);
    end
  endtask

  task automatic hchk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  typedef struct {
    int            inst;
    int            due;
    int            id;
    logic [DW-1:0] data;
  } rsp_t;

  rsp_t exq[$];
  int   m_prio = 0;
  int   m_burst = 0;
  bit   m_locked = 1'b0;

  // request-level model: who wins this cycle, and which reads come back when
  initial begin
    forever begin
      int            eg;
      logic          ewe;
      logic [AW-1:0] ea;
      logic [DW-1:0] ed;
      @(negedge clk);
      if (!rst) begin
        eg = -1;
        m_prio = 0; m_burst = 0; m_locked = 1'b0;
        exq.delete();
      end else if (m_locked) eg = req1 ? 1 : -1;
      else if (req0 && req1) eg = m_prio;
      else if (req0) eg = 0;
      else if (req1) eg = 1;
      else eg = -1;
      ewe = (eg == 0) ? we0 : (eg == 1) ? we1 : 1'b0;
      ea  = (eg == 0) ? addr0 : (eg == 1) ? addr1 : '0;
      ed  = (eg == 0) ? wdata0 : (eg == 1) ? wdata1 : '0;

      for (int k = 0; k < NI; k++) begin
        logic          ev0, ev1;
        logic [DW-1:0] ex0, ex1;
        ev0 = 1'b0; ev1 = 1'b0; ex0 = '0; ex1 = '0;
        foreach (exq[j]) begin
          if (exq[j].inst == k && exq[j].due == cyc) begin
            if (exq[j].id == 0) begin ev0 = 1'b1; ex0 = exq[j].data; end
            else begin ev1 = 1'b1; ex1 = exq[j].data; end
          end
        end
        chk("gnt0", k, 64'(gnt0_w[k]), 64'(eg == 0));
        chk("gnt1", k, 64'(gnt1_w[k]), 64'(eg == 1));
        chk("core_stall", k, 64'(stall_w[k]), 64'(rst && req0 && eg != 0));
        chk("mem_read_en", k, 64'(mre_w[k]), 64'(eg >= 0 && !ewe));
        chk("mem_write_en", k, 64'(mwe_w[k]), 64'(eg >= 0 && ewe));
        chk("mem_addr", k, 64'(maddr_w[k]), 64'(ea));
        chk("mem_wdata", k, 64'(mwdata_w[k]), 64'(ed));
        chk("rvalid0", k, 64'(rvalid0_w[k]), 64'(ev0));
        chk("rvalid1", k, 64'(rvalid1_w[k]), 64'(ev1));
        chk("rdata0", k, 64'(rdata0_w[k]), 64'(ex0));
        chk("rdata1", k, 64'(rdata1_w[k]), 64'(ex1));
      end

      for (int j = exq.size() - 1; j >= 0; j--) begin
        if (exq[j].due <= cyc) exq.delete(j);
      end
      if (eg >= 0 && !ewe) begin
        for (int k = 0; k < NI; k++) exq.push_back('{inst: k, due: cyc + k + 1, id: eg, data: mem_f(ea)});
      end

      if (rst) begin
        if (m_locked) begin
          if (eg == 1) m_burst++;
          if (!lock1 || !req1 || m_burst >= MAXL) begin
            m_locked = 1'b0; m_burst = 0; m_prio = 0;
          end
        end else if (eg == 0) begin
          m_prio = 1;
        end else if (eg == 1) begin
          m_prio = 0;
          if (lock1 && MAXL > 1) begin
            m_locked = 1'b1; m_burst = 1;
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drv(input logic r0, input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                     input logic r1, input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                     input logic l1);
    @(posedge clk);
    #1;
    req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
    lock1 = l1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drv(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1; rst = 1'b1;
  endtask

  initial begin
    logic [5:0] g6, s6;
    logic [4:0] g5, s5;
    rst = 1'b0;
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0; lock1 = 1'b0;
    addr0 = 32'h10; addr1 = 32'h20; wdata0 = '0; wdata1 = '0;
    repeat (2) @(negedge clk);
    hchk("reset_gnt0", 64'(gnt0_w[0]), 64'(0));
    hchk("reset_stall", 64'(stall_w[0]), 64'(0));
    @(posedge clk); #1;
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;

    // single core read, latency 1
    drv(1'b1, 1'b0, 32'h40, '0, 1'b0, 1'b0, '0, '0, 1'b0);
    @(negedge clk);
    hchk("t1_gnt0", 64'(gnt0_w[0]), 64'(1));
    hchk("t1_read_en", 64'(mre_w[0]), 64'(1));
    hchk("t1_addr", 64'(maddr_w[0]), 64'(32'h40));
    idle(1);
    @(negedge clk);
    hchk("t1_rvalid0", 64'(rvalid0_w[0]), 64'(1));
    hchk("t1_rdata0", 64'(rdata0_w[0]), 64'(32'h1234_5638));
    hchk("t1_rvalid1", 64'(rvalid1_w[0]), 64'(0));
    idle(4);

    // contended reads alternate after reset
    pulse_reset();
    g6 = '0; s6 = '0;
    for (int i = 0; i < 6; i++) begin
      drv(1'b1, 1'b0, 32'h10, '0, 1'b1, 1'b0, 32'h200, '0, 1'b0);
      @(negedge clk);
      g6 = {g6[4:0], gnt0_w[0]};
      s6 = {s6[4:0], stall_w[0]};
    end
    hchk("rr_gnt0_pattern", 64'(g6), 64'(6'b101010));
    hchk("rr_stall_pattern", 64'(s6), 64'(6'b010101));
    idle(4);

    // lock burst bounded at MAX_LOCK, then forced release to the core
    drv(1'b1, 1'b0, 32'h20, '0, 1'b0, 1'b0, '0, '0, 1'b0);
    g5 = '0; s5 = '0;
    for (int i = 0; i < 5; i++) begin
      drv(1'b1, 1'b0, 32'h24, '0, 1'b1, 1'b0, 32'h300, '0, 1'b1);
      @(negedge clk);
      g5 = {g5[3:0], gnt1_w[0]};
      s5 = {s5[3:0], stall_w[0]};
    end
    hchk("lock_gnt1_pattern", 64'(g5), 64'(5'b11110));
    hchk("lock_stall_pattern", 64'(s5), 64'(5'b11110));
    idle(4);

    // port 1 write beside a port 0 read, latency 3
    drv(1'b1, 1'b0, 32'h80, '0, 1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 1'b0);
    @(negedge clk);
    hchk("t4_gnt1", 64'(gnt1_w[2]), 64'(1));
    hchk("t4_write_en", 64'(mwe_w[2]), 64'(1));
    hchk("t4_addr", 64'(maddr_w[2]), 64'(32'h100));
    hchk("t4_wdata", 64'(mwdata_w[2]), 64'(32'hDEAD_BEEF));
    drv(1'b1, 1'b0, 32'h80, '0, 1'b0, 1'b0, '0, '0, 1'b0);
    @(negedge clk);
    hchk("t4_gnt0", 64'(gnt0_w[2]), 64'(1));
    idle(1); @(negedge clk);
    hchk("t4_rvalid0_early1", 64'(rvalid0_w[2]), 64'(0));
    idle(1); @(negedge clk);
    hchk("t4_rvalid0_early2", 64'(rvalid0_w[2]), 64'(0));
    idle(1); @(negedge clk);
    hchk("t4_rvalid0", 64'(rvalid0_w[2]), 64'(1));
    hchk("t4_rdata0", 64'(rdata0_w[2]), 64'(32'h1234_56F8));
    hchk("t4_rvalid1", 64'(rvalid1_w[2]), 64'(0));
    idle(3);

    // reset right after a granted read: the read is dropped
    drv(1'b1, 1'b0, 32'h44, '0, 1'b0, 1'b0, '0, '0, 1'b0);
    @(negedge clk);
    hchk("t5_gnt0", 64'(gnt0_w[1]), 64'(1));
    @(posedge clk); #1;
    rst = 1'b0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h48;
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'h148;
    @(negedge clk);
    hchk("t5_rst_gnt0", 64'(gnt0_w[1]), 64'(0));
    hchk("t5_rst_gnt1", 64'(gnt1_w[1]), 64'(0));
    hchk("t5_rst_read_en", 64'(mre_w[1]), 64'(0));
    hchk("t5_rst_stall", 64'(stall_w[1]), 64'(0));
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    hchk("t5_no_rvalid", 64'(rvalid0_w[1]), 64'(0));
    hchk("t5_first_gnt0", 64'(gnt0_w[1]), 64'(1));
    idle(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
